// File: rtl/gene_attractor_det_if.sv
// Bundle between the trajectory source and the attractor detector.
// The attr_sig member exists only when GENE_ATTR_SIG_EN is defined.
interface gene_attractor_det_if #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          start;
    logic          state_vld;
    logic [W-1:0]  state_in;
    logic          busy;
    logic          done;
    logic          fixed_pt;
    logic          overflow;
    logic [CW-1:0] period;
    logic [CW-1:0] transient;
`ifdef GENE_ATTR_SIG_EN
    logic [W-1:0]  attr_sig;
`endif

    modport master (
        output start, state_vld, state_in,
        input  busy, done, fixed_pt, overflow, period, transient
`ifdef GENE_ATTR_SIG_EN
        , input attr_sig
`endif
    );

    modport slave (
        input  start, state_vld, state_in,
        output busy, done, fixed_pt, overflow, period, transient
`ifdef GENE_ATTR_SIG_EN
        , output attr_sig
`endif
    );
endinterface

// File: rtl/gene_attractor_det.sv
// Tracks a Boolean-network trajectory after start and reports the transient length,
// cycle period and fixed-point flag of its attractor. GENE_ATTR_SIG_EN adds attr_sig.
module gene_attractor_det #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    gene_attractor_det_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] transient_q, transient_d;
    logic          fixed_q, fixed_d;
    logic          overflow_q, overflow_d;
    logic [W-1:0]  buf_q [DEPTH];
    logic          wr_en;
    logic          accept;
    logic          match;
    logic [CW-1:0] match_idx;
`ifdef GENE_ATTR_SIG_EN
    logic [W-1:0]  sig_q, sig_d, sig_c;
`endif

    // start wins over a coincident sample, so that sample never enters history
    assign accept = (state_q == S_TRACK) && bus.state_vld && !bus.start;

    // Descending scan leaves the lowest matching index in match_idx.
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if ((CW'(j) < cnt_q) && (buf_q[j] == bus.state_in)) begin
                match     = 1'b1;
                match_idx = CW'(j);
            end
        end
    end

`ifdef GENE_ATTR_SIG_EN
    always_comb begin
        sig_c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) >= match_idx) && (CW'(k) < cnt_q)) sig_c = sig_c ^ buf_q[k];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_TRACK;
            S_TRACK: begin
                if (bus.start)                                   state_d = S_TRACK;
                else if (accept && (match || cnt_q == CW'(DEPTH))) state_d = S_DONE;
            end
            S_DONE:  if (bus.start) state_d = S_TRACK;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        period_d    = period_q;
        transient_d = transient_q;
        fixed_d     = fixed_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;
`ifdef GENE_ATTR_SIG_EN
        sig_d       = sig_q;
`endif
        if (bus.start) begin
            cnt_d       = '0;
            period_d    = '0;
            transient_d = '0;
            fixed_d     = 1'b0;
            overflow_d  = 1'b0;
`ifdef GENE_ATTR_SIG_EN
            sig_d       = '0;
`endif
        end else if (accept) begin
            if (match) begin
                period_d    = cnt_q - match_idx;
                transient_d = match_idx;
                fixed_d     = ((cnt_q - match_idx) == CW'(1));
`ifdef GENE_ATTR_SIG_EN
                sig_d       = sig_c;
`endif
            end else if (cnt_q < CW'(DEPTH)) begin
                wr_en = 1'b1;
                cnt_d = cnt_q + CW'(1);
            end else begin
                overflow_d  = 1'b1;
                period_d    = '0;
                transient_d = '0;
`ifdef GENE_ATTR_SIG_EN
                sig_d       = '0;
`endif
            end
        end
    end

    // NOTE: sequential blocks use non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            transient_q <= '0;
            fixed_q     <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef GENE_ATTR_SIG_EN
            sig_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            transient_q <= transient_d;
            fixed_q     <= fixed_d;
            overflow_q  <= overflow_d;
`ifdef GENE_ATTR_SIG_EN
            sig_q       <= sig_d;
`endif
        end
    end

    // NOTE: history has no reset; entries at or above cnt_q are never compared, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[cnt_q[AW-1:0]] <= bus.state_in;
    end

    assign bus.busy      = (state_q == S_TRACK);
    assign bus.done      = (state_q == S_DONE);
    assign bus.fixed_pt  = fixed_q;
    assign bus.overflow  = overflow_q;
    assign bus.period    = period_q;
    assign bus.transient = transient_q;
`ifdef GENE_ATTR_SIG_EN
    assign bus.attr_sig  = sig_q;
`endif
endmodule

// File: tb/tb_gene_attractor_det.sv
// Self-checking bench for gene_attractor_det: table-driven trajectories plus
// hand-written restart, overflow, reset and hold sequences, scored through a queue.
module tb_gene_attractor_det;
    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    gene_attractor_det_if #(.W(W), .DEPTH(DEPTH)) bus ();

    gene_attractor_det #(.W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] samples;  // sample i in bits [8i+7:8i]
        int          n;
        logic [31:0] gaps;     // idle cycles after sample i in nibble i
        int          period;
        int          transient;
        logic        fixed;
        logic [7:0]  sig;
    } vec_t;

    typedef struct {
        int         period;
        int         transient;
        logic       fixed;
        logic       overflow;
        logic [7:0] sig;
    } exp_t;

    vec_t vecs [5];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        bus.state_vld = 1'b1;
        bus.state_in  = v;
        tick();
        bus.state_vld = 1'b0;
    endtask

    task automatic push_exp(input int p, input int t, input logic f, input logic o, input logic [7:0] s);
        exp_t e;
        e.period = p; e.transient = t; e.fixed = f; e.overflow = o; e.sig = s;
        sb.push_back(e);
    endtask

    // Results must already be visible right after the completing sample's edge.
    task automatic expect_done(input string name);
        exp_t e;
        int   lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_done"}, {31'd0, bus.done}, 32'd1);
        check({name, "_latency"}, lat, 0);
        check({name, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
        if (sb.size() == 0) begin
            check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "_period"}, 32'(bus.period), e.period);
            check({name, "_transient"}, 32'(bus.transient), e.transient);
            check({name, "_fixed_pt"}, {31'd0, bus.fixed_pt}, {31'd0, e.fixed});
            check({name, "_overflow"}, {31'd0, bus.overflow}, {31'd0, e.overflow});
`ifdef GENE_ATTR_SIG_EN
            check({name, "_attr_sig"}, 32'(bus.attr_sig), 32'(e.sig));
`endif
        end
    endtask

    task automatic expect_tracking(input string name);
        check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
        check({name, "_not_done"}, {31'd0, bus.done}, 32'd0);
    endtask

    function automatic vec_t mk(input logic [63:0] s, input int n, input logic [31:0] g,
                                input int p, input int t, input logic f, input logic [7:0] sig);
        vec_t v;
        v.samples = s; v.n = n; v.gaps = g; v.period = p; v.transient = t; v.fixed = f; v.sig = sig;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(64'h0000,               2, 32'h0,  1, 0, 1'b1, 8'h00);
        vecs[1] = mk(64'h22_44_33_22_11,     5, 32'h0,  3, 1, 1'b0, 8'h55);
        vecs[2] = mk(64'h05_06_05,           3, 32'h13, 2, 0, 1'b0, 8'h03);
        vecs[3] = mk(64'h01_03_02_01,        4, 32'h0,  3, 0, 1'b0, 8'h00);
        vecs[4] = mk(64'hBB_BB_AA,           3, 32'h0,  1, 1, 1'b1, 8'hBB);

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.state_vld = 1'b0;
        bus.state_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_overflow", {31'd0, bus.overflow}, 32'd0);
        check("reset_period", 32'(bus.period), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_start();
            push_exp(vecs[i].period, vecs[i].transient, vecs[i].fixed, 1'b0, vecs[i].sig);
            for (int k = 0; k < vecs[i].n; k++) begin
                send(vecs[i].samples[k*8 +: 8]);
                if (k < vecs[i].n - 1) begin
                    expect_tracking($sformatf("vec%0d_s%0d", i, k));
                    repeat (int'(vecs[i].gaps[k*4 +: 4])) tick();
                end
            end
            expect_done($sformatf("vec%0d", i));
        end

        // done and results hold through later samples until the next start
        send(8'hBB);
        send(8'h12);
        idle_check: begin
            check("hold_done", {31'd0, bus.done}, 32'd1);
            check("hold_period", 32'(bus.period), 32'd1);
            check("hold_transient", 32'(bus.transient), 32'd1);
        end

        // Overflow: DEPTH distinct values fill history, the next distinct one overflows
        do_start();
        push_exp(0, 0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            send(8'(i));
            if (i == DEPTH - 1) expect_tracking("ovf_full");
        end
        send(8'(DEPTH));
        expect_done("ovf");

        // Restart discards history: 0x03 after the second start must not match
        do_start();
        send(8'h01); send(8'h02); send(8'h03);
        do_start();
        check("restart_cleared_done", {31'd0, bus.done}, 32'd0);
        push_exp(1, 1, 1'b1, 1'b0, 8'h07);
        send(8'h03);
        expect_tracking("restart_stale");
        send(8'h07);
        send(8'h07);
        expect_done("restart");

        // A sample coincident with start is dropped
        bus.start     = 1'b1;
        bus.state_vld = 1'b1;
        bus.state_in  = 8'h09;
        tick();
        bus.start     = 1'b0;
        bus.state_vld = 1'b0;
        push_exp(2, 0, 1'b0, 1'b0, 8'h03);
        send(8'h0A);
        send(8'h09);
        expect_tracking("drop_coincident");
        send(8'h0A);
        expect_done("drop");

        // Asynchronous reset mid-TRACK, then samples ignored until start
        do_start();
        send(8'h21); send(8'h22); send(8'h23);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_done", {31'd0, bus.done}, 32'd0);
        check("rst_mid_fixed", {31'd0, bus.fixed_pt}, 32'd0);
        check("rst_mid_transient", 32'(bus.transient), 32'd0);
        rst_n = 1'b1;
        tick();
        send(8'h01); send(8'h01);
        check("idle_ignore_done", {31'd0, bus.done}, 32'd0);
        check("idle_ignore_busy", {31'd0, bus.busy}, 32'd0);
        do_start();
        push_exp(1, 0, 1'b1, 1'b0, 8'h01);
        send(8'h01);
        send(8'h01);
        expect_done("post_reset");

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
